addsub_op_queue: RTL and testbench

Sequential operand-issue and result-capture stage wrapped around the team's combinational 8-bit add/subtract datapath. Buffers incoming operations in a small FIFO and presents the head operation to the adder's x/y/opcode inputs. Registers the adder's sum/carry_out/overflow into a valid/ready result port, which decouples producers and consumers of arithmetic from the adder's combinational path. Also keeps a saturating count of signed-overflow results.

---
 rtl/addsub_pkg.sv | 26 ++
 rtl/addsub_op_fifo.sv | 64 ++++++
 rtl/addsub_op_queue.sv | 106 ++++++++++
 tb/tb_addsub_op_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and constants for the 8-bit add/subtract datapath
// and its operand-issue/result-capture stage.
//   WIDTH_DEFAULT  default operand width of the adder
//   OP_ADD/OP_SUB  opcode encodings presented to the adder
//   addsub_op_t    {x, y, opcode} queued operation
//   addsub_res_t   {sum, carry, overflow} captured adder result
package addsub_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] x;
    logic [WIDTH_DEFAULT-1:0] y;
    logic                     opcode;
  } addsub_op_t;

  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] sum;
    logic                     carry;
    logic                     overflow;
  } addsub_res_t;

endpackage

// File: rtl/addsub_op_fifo.sv
// addsub_op_fifo: DEPTH-entry FIFO of queued operations with head read.
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write wr_data at the tail (ignored when full)
//   pop          drop the head entry (ignored when empty)
//   wr_data      entry to write
//   rd_data      head entry, all zeros when empty
//   count        entries currently stored
//   full, empty  occupancy flags
module addsub_op_fifo
  import addsub_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = addsub_op_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  entry_t                     wr_data,
  output entry_t                     rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head is taken from storage only; zero when nothing is queued.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/addsub_op_queue.sv
// addsub_op_queue: operand-issue / result-capture stage around the external
// combinational add/subtract datapath.
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              operation request handshake
//   in_x, in_y, in_opcode          operation (opcode 0 = add, 1 = subtract)
//   x, y, opcode                   head operation to the adder (0 when empty)
//   sum, carry_out, overflow       adder outputs
//   res_valid/res_ready            result handshake
//   res_sum, res_carry, res_overflow  captured result
//   count                          entries queued
//   ovf_count                      saturating count of overflowing results
module addsub_op_queue
  import addsub_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_x,
  input  logic [WIDTH-1:0]       in_y,
  input  logic                   in_opcode,
  output logic [WIDTH-1:0]       x,
  output logic [WIDTH-1:0]       y,
  output logic                   opcode,
  input  logic [WIDTH-1:0]       sum,
  input  logic                   carry_out,
  input  logic                   overflow,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_sum,
  output logic                   res_carry,
  output logic                   res_overflow,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             ovf_count
);

  // Width-generic equivalents of addsub_op_t / addsub_res_t.
  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             opcode;
  } op_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
  } res_t;

  op_t  wr_op;
  op_t  head;
  res_t res_q;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic cap;

  assign wr_op    = '{x: in_x, y: in_y, opcode: in_opcode};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  // Capture when there is a head and the result register is free or being
  // emptied this same edge.
  assign cap = !fifo_empty && (!res_valid || res_ready);

  addsub_op_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (op_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (cap),
    .wr_data (wr_op),
    .rd_data (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign x      = head.x;
  assign y      = head.y;
  assign opcode = head.opcode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_q     <= '0;
      ovf_count <= '0;
    end else if (cap) begin
      res_valid <= 1'b1;
      res_q     <= '{sum: sum, carry: carry_out, overflow: overflow};
      if (overflow && (ovf_count != '1)) ovf_count <= ovf_count + 8'd1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign res_sum      = res_q.sum;
  assign res_carry    = res_q.carry;
  assign res_overflow = res_q.overflow;

endmodule

// File: tb/tb_addsub_op_queue.sv
// tb_addsub_op_queue: directed and randomized bench for addsub_op_queue with a
// behavioural adder and an operation-level reference model.
module tb_addsub_op_queue;
  import addsub_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_x, in_y;
  logic       in_opcode;
  logic [7:0] x, y;
  logic       opcode;
  logic [7:0] sum;
  logic       carry_out, overflow;
  logic       res_valid, res_ready;
  logic [7:0] res_sum;
  logic       res_carry, res_overflow;
  logic [2:0] count;
  logic [7:0] ovf_count;

  int vectors     = 0;
  int miscompares = 0;

  addsub_op_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_opcode    (in_opcode),
    .x            (x),
    .y            (y),
    .opcode       (opcode),
    .sum          (sum),
    .carry_out    (carry_out),
    .overflow     (overflow),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_sum      (res_sum),
    .res_carry    (res_carry),
    .res_overflow (res_overflow),
    .count        (count),
    .ovf_count    (ovf_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the team's combinational adder.
  logic [8:0] add_t;
  always_comb begin
    add_t = '0;
    if (opcode == OP_SUB) add_t = {1'b0, x} + {1'b0, ~y} + 9'd1;
    else                  add_t = {1'b0, x} + {1'b0, y};
    sum       = add_t[7:0];
    carry_out = add_t[8];
    overflow  = (x[7] == (opcode ? ~y[7] : y[7])) && (add_t[7] != x[7]);
  end

  // Reference model: queue of pending operations plus the result register.
  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       op;
  } mop_t;

  mop_t       mq[$];
  bit         m_rv;
  logic [7:0] m_sum;
  bit         m_c, m_v;
  int         m_ovf;

  function automatic void calc(input mop_t o, output logic [7:0] s,
                               output bit c, output bit v);
    int ua, ub, sa, sb, u, sr;
    ua = int'(o.x);
    ub = int'(o.y);
    sa = int'($signed(o.x));
    sb = int'($signed(o.y));
    if (o.op) begin
      u  = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      u  = ua + ub;
      sr = sa + sb;
      c  = (u > 255);
    end
    s = u[7:0];
    v = (sr > 127) || (sr < -128);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_rv  = 0;
    m_sum = '0;
    m_c   = 0;
    m_v   = 0;
    m_ovf = 0;
  endfunction

  function automatic void model_edge(input bit iv, input logic [7:0] ix,
                                     input logic [7:0] iy, input bit iop,
                                     input bit rr);
    bit   cap, psh;
    mop_t n;
    cap = (mq.size() > 0) && (!m_rv || rr);
    psh = iv && (mq.size() < DEPTH);
    if (cap) begin
      calc(mq[0], m_sum, m_c, m_v);
      void'(mq.pop_front());
      m_rv = 1;
      if (m_v && m_ovf < 255) m_ovf++;
    end else if (m_rv && rr) begin
      m_rv = 0;
    end
    if (psh) begin
      n.x  = ix;
      n.y  = iy;
      n.op = iop;
      mq.push_back(n);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("res_valid", 32'(res_valid), 32'(m_rv));
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
    chk("res_sum", 32'(res_sum), 32'(m_sum));
    chk("res_carry", 32'(res_carry), 32'(m_c));
    chk("res_overflow", 32'(res_overflow), 32'(m_v));
    chk("head_x", 32'(x), (mq.size() > 0) ? 32'(mq[0].x) : 32'd0);
    chk("head_y", 32'(y), (mq.size() > 0) ? 32'(mq[0].y) : 32'd0);
    chk("head_op", 32'(opcode), (mq.size() > 0) ? 32'(mq[0].op) : 32'd0);
  endtask

  task automatic step(input bit iv, input logic [7:0] ix, input logic [7:0] iy,
                      input bit iop, input bit rr);
    in_valid  = iv;
    in_x      = ix;
    in_y      = iy;
    in_opcode = iop;
    res_ready = rr;
    @(posedge clk);
    model_edge(iv, ix, iy, iop, rr);
    #1;
    check_all();
  endtask

  // Reset asserted between edges; effects must be visible before any edge.
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_opcode = 1'b0;
    res_ready = 1'b0;
    model_reset();

    // Reset state
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 0x7F + 0x01: signed overflow, no carry
    step(1, 8'h7F, 8'h01, 0, 1);
    chk("t1_not_yet", 32'(res_valid), 32'd0);
    step(0, 8'h00, 8'h00, 0, 1);
    chk("t1_valid", 32'(res_valid), 32'd1);
    chk("t1_sum", 32'(res_sum), 32'h80);
    chk("t1_carry", 32'(res_carry), 32'd0);
    chk("t1_ovf", 32'(res_overflow), 32'd1);
    chk("t1_ovf_count", 32'(ovf_count), 32'd1);

    // Back-to-back subtracts
    step(1, 8'h05, 8'h03, 1, 1);
    step(1, 8'h00, 8'h01, 1, 1);
    chk("t2a_sum", 32'(res_sum), 32'h02);
    chk("t2a_carry", 32'(res_carry), 32'd1);
    chk("t2a_ovf", 32'(res_overflow), 32'd0);
    step(0, 8'h00, 8'h00, 0, 1);
    chk("t2b_sum", 32'(res_sum), 32'hFF);
    chk("t2b_carry", 32'(res_carry), 32'd0);
    chk("t2b_ovf", 32'(res_overflow), 32'd0);
    step(0, 8'h00, 8'h00, 0, 1);
    chk("t2_drained", 32'(res_valid), 32'd0);

    // Back-pressure: fill result register and queue
    for (int unsigned i = 0; i < 6; i++)
      step(1, 8'(8'h10 + i), 8'(i), i[0], 0);
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    // Full with push and pop offered together
    for (int unsigned i = 0; i < 6; i++)
      step(1, 8'(8'h30 + i), 8'(8'h81 + i), i[1], 1);
    // Drain
    for (int unsigned i = 0; i < 7; i++)
      step(0, 8'h00, 8'h00, 0, 1);
    chk("t3_empty", 32'(count), 32'd0);

    // Reset mid-stream with 3 queued (one more held in the result register)
    step(1, 8'h40, 8'h40, 0, 0);
    step(1, 8'h41, 8'h02, 1, 0);
    step(1, 8'h42, 8'h03, 0, 0);
    step(1, 8'h43, 8'h04, 1, 0);
    chk("t4_pre_count", 32'(count), 32'd3);
    do_reset();
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_in_ready", 32'(in_ready), 32'd1);
    step(1, 8'h12, 8'h34, 0, 1);
    step(0, 8'h00, 8'h00, 0, 1);
    chk("t4_sum", 32'(res_sum), 32'h46);
    chk("t4_ovf_count", 32'(ovf_count), 32'd0);

    // Saturation of ovf_count
    for (int unsigned i = 0; i < 260; i++)
      step(1, 8'h40, 8'h40, 0, 1);
    for (int unsigned i = 0; i < 3; i++)
      step(0, 8'h00, 8'h00, 0, 1);
    chk("t5_ovf_sat", 32'(ovf_count), 32'd255);

    // Randomized traffic
    for (int unsigned i = 0; i < 400; i++) begin
      logic [7:0] rx, ry;
      rx = 8'($urandom);
      ry = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rx = 8'h80;
      if ($urandom_range(0, 7) == 0) ry = 8'h7F;
      step($urandom_range(0, 3) != 0, rx, ry, 1'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int unsigned i = 0; i < 8; i++)
      step(0, 8'h00, 8'h00, 0, 1);
    chk("final_empty", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
